// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams, TX FIFO write port and grant status shared by the arbiter.
// master = requesters/FIFO side, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               fifo_we;
    logic [7:0]         fifo_din;
    logic               fifo_full;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               timeout;
    logic [ID_W-1:0]    timeout_id;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_we, fifo_din, grant_valid, grant_id, timeout, timeout_id
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_we, fifo_din, grant_valid, grant_id, timeout, timeout_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet round-robin arbiter onto the UART TX FIFO: 1-cycle grant, then 1 byte/cycle with bytes passed combinationally.
// fifo_full stalls the granted requester via req_ready; only an idle requester (not backpressure) trips the watchdog.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int ID_W         = $clog2(N_REQ),
    parameter int IDLE_TIMEOUT = 1024,
    parameter int TO_W         = $clog2(IDLE_TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_grant_valid;
    logic [ID_W-1:0] r_grant_id;
    logic [ID_W-1:0] r_last_id;
    logic [ID_W-1:0] r_timeout_id;
    logic [TO_W-1:0] r_cnt;

    state_t          w_state_nxt;
    logic            w_grant_valid_nxt;
    logic [ID_W-1:0] w_grant_id_nxt;
    logic [ID_W-1:0] w_last_id_nxt;
    logic [ID_W-1:0] w_timeout_id_nxt;
    logic [TO_W-1:0] w_cnt_nxt;

    logic            w_any;
    logic [ID_W-1:0] w_pick;
    logic [ID_W-1:0] w_cand;
    logic            w_g_vld;
    logic            w_g_last;
    logic [7:0]      w_g_dat;
    logic [N_REQ-1:0] w_req_ready;
    logic            w_fifo_we;
    logic [7:0]      w_fifo_din;
    logic            w_timeout;

    // Circular search starting just after the last served requester.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = ID_W'((int'(r_last_id) + k) % N_REQ);
            if (!w_any && bus.req_valid[w_cand]) begin
                w_any  = 1'b1;
                w_pick = w_cand;
            end
        end
    end

    assign w_g_vld  = bus.req_valid[r_grant_id];
    assign w_g_last = bus.req_last[r_grant_id];
    assign w_g_dat  = bus.req_data[{r_grant_id, 3'b000} +: 8];

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_id_nxt    = r_grant_id;
        w_last_id_nxt     = r_last_id;
        w_timeout_id_nxt  = r_timeout_id;
        w_cnt_nxt         = r_cnt;
        w_req_ready       = '0;
        w_fifo_we         = 1'b0;
        w_fifo_din        = 8'h00;
        w_timeout         = 1'b0;

        case (r_state)
            ST_ARB: begin
                if (w_any) begin
                    w_grant_id_nxt    = w_pick;
                    w_grant_valid_nxt = 1'b1;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = ST_XFER;
                end
            end
            ST_XFER: begin
                w_req_ready[r_grant_id] = ~bus.fifo_full;
                w_fifo_we               = w_g_vld & ~bus.fifo_full;
                w_fifo_din              = w_fifo_we ? w_g_dat : 8'h00;
                if (w_fifo_we && w_g_last) begin
                    w_last_id_nxt     = r_grant_id;
                    w_grant_valid_nxt = 1'b0;
                    w_state_nxt       = ST_ARB;
                end else if (w_g_vld) begin
                    // A requester presenting data is never idle, even when the FIFO is full.
                    w_cnt_nxt = '0;
                end else if (r_cnt == TO_W'(IDLE_TIMEOUT - 1)) begin
                    w_timeout         = 1'b1;
                    w_timeout_id_nxt  = r_grant_id;
                    w_last_id_nxt     = r_grant_id;
                    w_grant_valid_nxt = 1'b0;
                    w_state_nxt       = ST_ARB;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt       = ST_ARB;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_ARB;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_last_id     <= ID_W'(N_REQ - 1);
            r_timeout_id  <= '0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_last_id     <= w_last_id_nxt;
            r_timeout_id  <= w_timeout_id_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.fifo_we     = w_fifo_we;
    assign bus.fifo_din    = w_fifo_din;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout     = w_timeout;
    assign bus.timeout_id  = r_timeout_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester source queues feed the DUT, per-requester
// expected-byte queues are popped by a monitor whenever fifo_we fires.
module tb_uart_tx_arbiter;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int TOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N), .ID_W(IDW)) bus();

    uart_tx_arbiter #(.N_REQ(N), .ID_W(IDW), .IDLE_TIMEOUT(TOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] src_q [N][$];
    logic [7:0] exp_q [N][$];
    int         grant_log[$];
    int         gap_log[$];
    int         cyc     = 0;
    int         to_cnt  = 0;
    int         to_cyc  = -1;
    int         gap_cnt = 0;
    int         wr_cnt  = 0;
    logic       prev_gv = 1'b0;
    bit         acc [N];
    logic [7:0] mon_exp;

    // Requester driver: pops an entry one cycle after it was seen accepted.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) acc[i] = bus.req_valid[i] && bus.req_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[i*8 +: 8] = src_q[i][0][7:0];
                    bus.req_last[i]        = src_q[i][0][8];
                end else begin
                    bus.req_valid[i]       = 1'b0;
                    bus.req_data[i*8 +: 8] = 8'h00;
                    bus.req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard on FIFO writes, ready one-hot rule, grant/timeout logging.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.fifo_we) begin
                    wr_cnt++;
                    checks++;
                    if (!bus.grant_valid || exp_q[bus.grant_id].size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: wrote %02h under id %0d gv=%0b, required no write", bus.fifo_din, bus.grant_id, bus.grant_valid);
                    end else begin
                        mon_exp = exp_q[bus.grant_id].pop_front();
                        if (bus.fifo_din !== mon_exp) begin
                            errors++;
                            $display("FAIL sb_byte: id %0d got %02h, required %02h", bus.grant_id, bus.fifo_din, mon_exp);
                        end
                    end
                end
                checks++;
                if ((bus.req_ready & ~(4'(1) << bus.grant_id)) != 4'b0 || (!bus.grant_valid && bus.req_ready != 4'b0)) begin
                    errors++;
                    $display("FAIL ready_onehot: req_ready=%b grant_id=%0d gv=%0b, required only granted bit", bus.req_ready, bus.grant_id, bus.grant_valid);
                end
                if (bus.timeout) begin
                    to_cnt++;
                    to_cyc = cyc;
                end
                if (bus.grant_valid && !prev_gv) begin
                    grant_log.push_back(int'(bus.grant_id));
                    gap_log.push_back(gap_cnt);
                    gap_cnt = 0;
                end else if (!bus.grant_valid) begin
                    gap_cnt++;
                end
            end
            prev_gv = bus.grant_valid;
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_pkt(input int id, input int n, input logic [7:0] base);
        for (int b = 0; b < n; b++) begin
            src_q[id].push_back({(b == n - 1), 8'(base + b)});
            exp_q[id].push_back(8'(base + b));
        end
    endtask

    task automatic wait_grant(input int id, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            tick();
            #1;
            if (bus.grant_valid && int'(bus.grant_id) == id) ok = 1'b1;
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        bit busy;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            tick();
            #1;
            busy = bus.grant_valid;
            for (int i = 0; i < N; i++) busy |= (src_q[i].size() != 0) || (exp_q[i].size() != 0);
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        repeat (3) tick();
        #1;
        checks += 7;
        if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rst_grant_valid: got %b, required 0", bus.grant_valid); end
        if (bus.grant_id !== 2'd0)    begin errors++; $display("FAIL rst_grant_id: got %0d, required 0", bus.grant_id); end
        if (bus.timeout !== 1'b0)     begin errors++; $display("FAIL rst_timeout: got %b, required 0", bus.timeout); end
        if (bus.timeout_id !== 2'd0)  begin errors++; $display("FAIL rst_timeout_id: got %0d, required 0", bus.timeout_id); end
        if (bus.req_ready !== 4'b0)   begin errors++; $display("FAIL rst_req_ready: got %b, required 0000", bus.req_ready); end
        if (bus.fifo_we !== 1'b0)     begin errors++; $display("FAIL rst_fifo_we: got %b, required 0", bus.fifo_we); end
        if (bus.fifo_din !== 8'h00)   begin errors++; $display("FAIL rst_fifo_din: got %02h, required 00", bus.fifo_din); end
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL idle_no_grant: got %b, required 0", bus.grant_valid); end
    endtask

    task automatic test_single();
        bit ok;
        tick();
        send_pkt(2, 3, 8'hA1);
        tick();
        #1;
        checks++;
        if (bus.grant_valid !== 1'b0 || bus.fifo_we !== 1'b0) begin
            errors++; $display("FAIL single_arb_cycle: gv=%b we=%b, required 0 0", bus.grant_valid, bus.fifo_we);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd2 || bus.fifo_we !== 1'b1 ||
                bus.fifo_din !== 8'(8'hA1 + k) || bus.req_ready !== 4'b0100) begin
                errors++;
                $display("FAIL single_beat%0d: gv=%b id=%0d we=%b din=%02h rdy=%b, required 1 2 1 %02h 0100",
                         k, bus.grant_valid, bus.grant_id, bus.fifo_we, bus.fifo_din, bus.req_ready, 8'(8'hA1 + k));
            end
        end
        tick();
        #1;
        checks++;
        if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL single_release: gv=%b, required 0", bus.grant_valid); end
        wait_drain(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_drain: drained=0, required 1"); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int base;
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        grant_log.delete();
        gap_log.delete();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < N; i++) send_pkt(i, 2, 8'(16 * (i + 1) + 2 * p));
        wait_drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rr_drain: drained=0, required 1"); end
        checks++;
        if (grant_log.size() != 12) begin
            errors++; $display("FAIL rr_count: got %0d grants, required 12", grant_log.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (grant_log[k] != k % N) begin
                    errors++; $display("FAIL rr_order%0d: got %0d, required %0d", k, grant_log[k], k % N);
                end
                if (k > 0) begin
                    checks++;
                    if (gap_log[k] != 1) begin
                        errors++; $display("FAIL rr_bubble%0d: got %0d idle cycles, required 1", k, gap_log[k]);
                    end
                end
            end
        end
        base = 0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad_rdy, bad_we, bad_to, bad_gv, w0, t0;
        bad_rdy = 0; bad_we = 0; bad_to = 0; bad_gv = 0;
        w0 = wr_cnt;
        t0 = to_cnt;
        send_pkt(1, 4, 8'hB0);
        wait_grant(1, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_grant: granted=0, required 1"); end
        tick();
        bus.fifo_full = 1'b1;
        #1;
        for (int c = 0; c < 2000; c++) begin
            if (bus.req_ready !== 4'b0) bad_rdy++;
            if (bus.fifo_we !== 1'b0)   bad_we++;
            if (bus.timeout !== 1'b0)   bad_to++;
            if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd1) bad_gv++;
            tick();
            #1;
        end
        bus.fifo_full = 1'b0;
        wait_drain(20, ok);
        checks += 7;
        if (bad_rdy != 0) begin errors++; $display("FAIL bp_ready: %0d cycles ready high, required 0", bad_rdy); end
        if (bad_we != 0)  begin errors++; $display("FAIL bp_we: %0d cycles we high, required 0", bad_we); end
        if (bad_to != 0)  begin errors++; $display("FAIL bp_timeout: %0d timeout cycles, required 0", bad_to); end
        if (bad_gv != 0)  begin errors++; $display("FAIL bp_grant_held: %0d cycles grant lost, required 0", bad_gv); end
        if (to_cnt != t0) begin errors++; $display("FAIL bp_to_cnt: got %0d pulses, required 0", to_cnt - t0); end
        if (wr_cnt - w0 != 4) begin errors++; $display("FAIL bp_bytes: got %0d writes, required 4", wr_cnt - w0); end
        if (!ok) begin errors++; $display("FAIL bp_drain: drained=0, required 1"); end
    endtask

    task automatic test_stall_timeout();
        bit ok;
        int t0, g;
        t0 = to_cnt;
        src_q[3].push_back({1'b0, 8'hC0});
        exp_q[3].push_back(8'hC0);
        wait_grant(3, 20, ok);
        g = cyc;
        checks++;
        if (!ok) begin errors++; $display("FAIL to_grant3: granted=0, required 1"); end
        send_pkt(0, 2, 8'hD0);
        wait_drain(60, ok);
        checks += 5;
        if (!ok) begin errors++; $display("FAIL to_drain: drained=0, required 1"); end
        if (to_cnt - t0 != 1) begin errors++; $display("FAIL to_pulses: got %0d, required 1", to_cnt - t0); end
        if (to_cyc != g + TOUT) begin errors++; $display("FAIL to_timing: pulse at cycle %0d, required %0d", to_cyc, g + TOUT); end
        if (bus.timeout_id !== 2'd3) begin errors++; $display("FAIL to_id: got %0d, required 3", bus.timeout_id); end
        if (grant_log.size() == 0 || grant_log[grant_log.size() - 1] != 0) begin
            errors++; $display("FAIL to_next_grant: last grant not requester 0, required 0");
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int gsz;
        send_pkt(0, 6, 8'hE0);
        wait_grant(0, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rm_grant0: granted=0, required 1"); end
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.fifo_we !== 1'b0)     begin errors++; $display("FAIL rm_we: got %b, required 0", bus.fifo_we); end
        if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL rm_gv: got %b, required 0", bus.grant_valid); end
        if (bus.req_ready !== 4'b0)   begin errors++; $display("FAIL rm_ready: got %b, required 0000", bus.req_ready); end
        src_q[0].delete();
        exp_q[0].delete();
        send_pkt(3, 2, 8'h71);
        send_pkt(1, 2, 8'h51);
        gsz = grant_log.size();
        tick();
        tick();
        rst_n = 1'b1;
        wait_drain(40, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL rm_drain: drained=0, required 1"); end
        if (grant_log.size() < gsz + 2 || grant_log[gsz] != 1 || grant_log[gsz + 1] != 3) begin
            errors++; $display("FAIL rm_order: grants after reset not 1 then 3, required 1,3");
        end
    endtask

    task automatic test_last_full();
        bit ok;
        send_pkt(2, 2, 8'hF0);
        wait_grant(2, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lf_grant: granted=0, required 1"); end
        tick();
        bus.fifo_full = 1'b1;
        #1;
        checks++;
        if (bus.fifo_we !== 1'b0 || bus.req_ready !== 4'b0 || bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd2) begin
            errors++; $display("FAIL lf_held: we=%b rdy=%b gv=%b id=%0d, required 0 0000 1 2", bus.fifo_we, bus.req_ready, bus.grant_valid, bus.grant_id);
        end
        tick();
        #1;
        checks++;
        if (bus.grant_valid !== 1'b1) begin errors++; $display("FAIL lf_kept: gv=%b, required 1", bus.grant_valid); end
        tick();
        bus.fifo_full = 1'b0;
        #1;
        checks++;
        if (bus.fifo_we !== 1'b1 || bus.fifo_din !== 8'hF1 || bus.req_ready !== 4'b0100) begin
            errors++; $display("FAIL lf_accept: we=%b din=%02h rdy=%b, required 1 F1 0100", bus.fifo_we, bus.fifo_din, bus.req_ready);
        end
        tick();
        #1;
        checks++;
        if (bus.grant_valid !== 1'b0) begin errors++; $display("FAIL lf_release: gv=%b, required 0", bus.grant_valid); end
        wait_drain(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lf_drain: drained=0, required 1"); end
    endtask

    initial begin
        int left;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_stall_timeout();
        test_reset_mid();
        test_last_full();
        left = 0;
        for (int i = 0; i < N; i++) left += exp_q[i].size();
        checks++;
        if (left != 0) begin errors++; $display("FAIL sb_leftover: %0d bytes never written, required 0", left); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
